// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data/parity/stop deframer feeding a one-entry
// output register with a valid/ready handshake and per-frame error pulses.
module serial_frame_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             par_err,
  output logic             frm_err,
  output logic             ovr_err,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic             par_acc;
  logic             par_bad;

  // Deframing FSM, holding register handshake and error pulse generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      par_acc   <= 1'b0;
      par_bad   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Error outputs are single-cycle pulses.
      par_err <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;

      // Consumer accept; a load below on the same edge overrides this.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state   <= DATA;
              busy    <= 1'b1;
              cnt     <= '0;
              par_acc <= 1'b0;
              par_bad <= 1'b0;
            end
          end

          DATA: begin
            shift   <= {shift[WIDTH-2:0], sin};
            par_acc <= par_acc ^ sin;
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end

          PARITY: begin
            par_bad <= par_acc ^ sin;
            state   <= STOP;
          end

          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!sin) begin
              frm_err <= 1'b1;
            end else if (par_bad) begin
              par_err <= 1'b1;
            end else if (!out_valid || out_ready) begin
              out_data  <= shift;
              out_valid <= 1'b1;
            end else begin
              ovr_err <= 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: stimulus pushes expected words and
// error events, an independent monitor pops and compares what the DUT emits.
module tb_serial_frame_rx;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned PARITY_EN = 1;

  localparam int ERR_PAR = 1;
  localparam int ERR_FRM = 2;
  localparam int ERR_OVR = 3;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             sin       = 1'b1;
  logic             bit_en    = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             par_err;
  logic             frm_err;
  logic             ovr_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_words[$];
  int               exp_errs[$];

  serial_frame_rx #(.WIDTH(WIDTH), .PARITY_EN(PARITY_EN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .bit_en   (bit_en),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .par_err  (par_err),
    .frm_err  (frm_err),
    .ovr_err  (ovr_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_gap(input int gap, input bit rnd);
    return rnd ? int'($urandom_range(gap, 0)) : gap;
  endfunction

  // Present one bit, idle 'gap' unstrobed cycles, then strobe it in.
  task automatic send_bit(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b0;
    repeat (gap) tick();
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input logic pb, input logic sb,
                            input int gap, input bit rnd, input bit ready_at_stop);
    send_bit(1'b0, pick_gap(gap, rnd));
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(d[i], pick_gap(gap, rnd));
    if (PARITY_EN != 0) send_bit(pb, pick_gap(gap, rnd));
    if (ready_at_stop) out_ready = 1'b1;
    send_bit(sb, pick_gap(gap, rnd));
    sin = 1'b1;
  endtask

  // Reference model: outcome of one frame from its contents and whether the
  // holding register is occupied and unread when the stop bit lands.
  task automatic expect_frame(input logic [WIDTH-1:0] d, input logic pb, input logic sb,
                              input bit held_full);
    logic even_ok;
    even_ok = (PARITY_EN == 0) || ((^d ^ pb) == 1'b0);
    if (!sb)            exp_errs.push_back(ERR_FRM);
    else if (!even_ok)  exp_errs.push_back(ERR_PAR);
    else if (held_full) exp_errs.push_back(ERR_OVR);
    else                exp_words.push_back(d);
  endtask

  // Monitor: compares accepted words and error pulses against the scoreboard.
  logic             prev_hold;
  logic [WIDTH-1:0] prev_data;
  logic [2:0]       prev_err;
  initial begin
    prev_hold = 1'b0;
    prev_data = '0;
    prev_err  = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_err  = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_words.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          check("word", 32'(out_data), 32'(exp_words.pop_front()));
        end
      end
      if (par_err || frm_err || ovr_err) begin
        int code;
        code = par_err ? ERR_PAR : (frm_err ? ERR_FRM : ERR_OVR);
        check("err_onehot", 32'(par_err) + 32'(frm_err) + 32'(ovr_err), 32'd1);
        if (exp_errs.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_err: got kind %0d expected none", code);
        end else begin
          check("err_kind", 32'(code), 32'(exp_errs.pop_front()));
        end
      end
      if (prev_err != 3'b000) check("err_pulse_len", {29'd0, par_err, frm_err, ovr_err}, 32'd0);
      if (prev_hold && out_valid) check("hold_stable", 32'(out_data), 32'(prev_data));
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_err  = {par_err, frm_err, ovr_err};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] d;
    logic             pb;
    logic             sb;
    int               r;

    // Reset values.
    #2 rst_n = 1'b0;
    #10;
    check("reset_outs", {25'd0, out_data, out_valid, par_err, frm_err, ovr_err, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();

    // Good frame 0xB, bit_en every cycle, ready high.
    send_bit(1'b0, 0);
    check("t1_busy_start", 32'(busy), 32'd1);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    check("t1_busy_parity", 32'(busy), 32'd1);
    exp_words.push_back(4'hB);
    send_bit(1'b1, 0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'hB);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_err", {29'd0, par_err, frm_err, ovr_err}, 32'd0);
    tick();
    check("t1_valid_drop", 32'(out_valid), 32'd0);

    // Bad parity, then 0x3.
    expect_frame(4'hB, 1'b0, 1'b1, 1'b0);
    send_frame(4'hB, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("t2_par_err", 32'(par_err), 32'd1);
    check("t2_no_valid", 32'(out_valid), 32'd0);
    tick();
    check("t2_par_clear", 32'(par_err), 32'd0);
    expect_frame(4'h3, 1'b0, 1'b1, 1'b0);
    send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("t2_data", 32'(out_data), 32'h3);
    tick();

    // Framing error, then 0x6.
    expect_frame(4'hC, 1'b0, 1'b0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("t3_frm_err", 32'(frm_err), 32'd1);
    check("t3_no_valid", 32'(out_valid), 32'd0);
    tick();
    check("t3_frm_clear", 32'(frm_err), 32'd0);
    expect_frame(4'h6, 1'b0, 1'b1, 1'b0);
    send_frame(4'h6, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("t3_data", 32'(out_data), 32'h6);
    tick();

    // Overrun: ready low across two good frames.
    out_ready = 1'b0;
    expect_frame(4'hB, 1'b1, 1'b1, 1'b0);
    send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    expect_frame(4'h3, 1'b0, 1'b1, 1'b1);
    send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("t4_ovr_err", 32'(ovr_err), 32'd1);
    check("t4_held", 32'(out_data), 32'hB);
    tick();
    check("t4_ovr_clear", 32'(ovr_err), 32'd0);
    check("t4_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("t4_drained", 32'(out_valid), 32'd0);

    // Back-to-back: accept of 0x5 coincides with load of 0xA.
    out_ready = 1'b0;
    expect_frame(4'h5, 1'b0, 1'b1, 1'b0);
    send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    expect_frame(4'hA, 1'b0, 1'b1, 1'b0);
    send_frame(4'hA, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    check("t5_valid_kept", 32'(out_valid), 32'd1);
    check("t5_data", 32'(out_data), 32'hA);
    check("t5_no_ovr", 32'(ovr_err), 32'd0);
    tick();
    check("t5_drained", 32'(out_valid), 32'd0);

    // Reset mid-frame with bit_en every 3rd cycle, then a clean 0xC.
    send_bit(1'b0, 2); send_bit(1'b1, 2); send_bit(1'b1, 2);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_reset_outs", {25'd0, out_data, out_valid, par_err, frm_err, ovr_err, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();
    expect_frame(4'hC, 1'b0, 1'b1, 1'b0);
    send_frame(4'hC, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    check("t6_data", 32'(out_data), 32'hC);
    check("t6_valid", 32'(out_valid), 32'd1);
    tick();

    // Randomized frames with random strobe gaps, idle bits and corruption.
    for (int n = 0; n < 40; n++) begin
      d  = WIDTH'($urandom);
      r  = int'($urandom_range(5, 0));
      sb = (r == 0) ? 1'b0 : 1'b1;
      pb = (^d) ^ ((r == 1) ? 1'b1 : 1'b0);
      repeat ($urandom_range(2, 0)) send_bit(1'b1, int'($urandom_range(2, 0)));
      expect_frame(d, pb, sb, 1'b0);
      send_frame(d, pb, sb, 2, 1'b1, 1'b0);
    end

    repeat (6) tick();
    check("words_left", 32'(exp_words.size()), 32'd0);
    check("errs_left", 32'(exp_errs.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
